load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL take parameter MEM_BYTES, default 512, the data memory size in bytes.
REQ-002 The block SHALL take parameter WAIT_CYCLES, default 1 (legal range 1-15), the number of cycles memory signals are held before sampling or completion.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  pipeline request present.
REQ-006 req_ready  out  1  unit accepts a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_byte  in  1  1 = byte access, 0 = word access.
REQ-009 req_signed  in  1  byte load sign-extends when 1; ignored otherwise.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data; a byte store uses bits [7:0].
REQ-012 resp_valid  out  1  response available.
REQ-013 resp_ready  in  1  pipeline consumes the response.
REQ-014 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-015 resp_err  out  1  request rejected: misaligned or out of range.
REQ-016 mem_raddr  out  32  memory read address.
REQ-017 mem_waddr  out  32  memory write address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_en  out  1  memory write enable; 0 = read, 1 = write (level-sensitive).
REQ-020 mem_byte_en  out  1  memory byte mode.
REQ-021 mem_data  in  32  memory read data, combinational from mem_raddr.

Function
REQ-022 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-023 req_ready SHALL be 1 exactly when state is IDLE and rst is 0; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-024 On acceptance, the unit SHALL register req_we, req_byte, req_signed, req_addr and req_wdata; all later pipeline input changes are ignored until the next acceptance.
REQ-025 Error check at acceptance: err = (!req_byte && req_addr[1:0] != 0) || (req_addr + (req_byte ? 0 : 3) >= MEM_BYTES), computed without 32-bit wrap.
REQ-026 On error, IDLE SHALL go to RESP with resp_err=1 and resp_rdata=0, and mem_en SHALL never be asserted for that request.
REQ-027 Without error, the sequence SHALL be IDLE -> SETUP for 1 cycle -> ACCESS for WAIT_CYCLES cycles -> RESP.
REQ-028 Latency: resp_valid SHALL rise on edge WAIT_CYCLES+2 after the accepting edge; for an error response it rises on edge 1.
REQ-029 Load: in SETUP and ACCESS, mem_raddr = registered address, mem_byte_en = registered byte flag, mem_en = 0 and mem_waddr = 0.
REQ-030 Load: mem_data SHALL be captured on the edge leaving ACCESS.
REQ-031 Load result: a word load returns mem_data; a byte load returns {24{mem_data[7]}, mem_data[7:0]} when signed and {24'b0, mem_data[7:0]} when unsigned.
REQ-032 Store: in SETUP and ACCESS, mem_waddr, mem_wdata and mem_byte_en SHALL be stable at the registered values, and mem_raddr = 0.
REQ-033 Store: mem_en SHALL be 1 only during the first ACCESS cycle, so exactly one cycle per store.
REQ-034 Store: mem_en SHALL be 0 in every other state and cycle.
REQ-035 Store: mem_waddr and mem_wdata SHALL not change in any cycle where mem_en=1 or in the cycle after it.
REQ-036 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until the edge where resp_ready=1, then go to IDLE.
REQ-037 resp_ready SHALL be ignored outside RESP.
REQ-038 resp_ready may already be 1 on entry to RESP, in which case RESP lasts exactly 1 cycle.
REQ-039 Only one request SHALL be outstanding; there is no request/response overlap, and a new request may be accepted in the cycle after the RESP handshake at the earliest.
REQ-040 In IDLE, mem_en, mem_byte_en, mem_raddr, mem_waddr and mem_wdata SHALL all be 0.

Reset
REQ-041 While rst=1, all outputs SHALL be 0 and state SHALL be IDLE, asynchronously.
REQ-042 Assertion of rst mid-operation SHALL drop mem_en to 0 immediately, abandon the transaction and produce no response.
REQ-043 After rst deasserts, req_ready SHALL be 1 in the same cycle.

Verification
REQ-044 Memory preloaded with byte[i]=i mod 256; load word, addr 0x08, WAIT_CYCLES=1 -> resp_rdata=0x0B0A0908, resp_err=0, resp_valid on edge 3.
REQ-045 Load byte, addr 0x85: signed -> 0xFFFFFF85; unsigned -> 0x00000085; mem_byte_en=1 throughout SETUP/ACCESS.
REQ-046 Store word 0xDEADBEEF at addr 0x10, then load word at 0x10 -> 0xDEADBEEF; mem_en high exactly 1 cycle; bytes 0x0F and 0x14 unchanged.
REQ-047 Load word at 0x06, and load byte at 0x200 with MEM_BYTES=512 -> resp_err=1, resp_rdata=0, resp_valid on edge 1, mem_en never 1.
REQ-048 Store byte 0x55 at 0x20 with rst pulsed during SETUP -> mem_en stays 0, byte 0x20 remains 0x20, no resp_valid; next request is accepted normally.
REQ-049 Backpressure: resp_ready low for 5 cycles in RESP -> resp_rdata/resp_err stable, req_ready=0 and req_valid ignored; after the handshake, req_ready=1 on the next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding load/store engine between a pipeline and a simple
// combinational-read data memory. A request is accepted in IDLE, checked for
// alignment and range, and then either answered immediately with an error or
// walked through SETUP (1 cycle) and ACCESS (WAIT_CYCLES cycles) before the
// response is presented in RESP until the pipeline takes it.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid / req_ready       request handshake
//   req_we, req_byte,
//   req_signed, req_addr,
//   req_wdata                   request fields (store / byte / sign / addr / data)
//   resp_valid / resp_ready     response handshake
//   resp_rdata, resp_err        load result (0 for stores/errors), error flag
//   mem_raddr, mem_waddr,
//   mem_wdata, mem_en,
//   mem_byte_en                 memory request (mem_en = one-cycle write strobe)
//   mem_data                    memory read data, combinational from mem_raddr
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_BYTES   = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_byte_en,
    input  logic [31:0] mem_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  wait_q, wait_d;

    logic        accept;
    logic        req_err;
    logic [32:0] end_addr;
    logic [31:0] load_val;
    logic        in_mem;
    logic        store_hold;

    // req_ready is gated by rst directly so it is low for the whole reset
    // pulse and rises in the same cycle reset is released.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Last byte touched, computed one bit wider so addresses near 2^32 do
    // not wrap back into range.
    assign end_addr = {1'b0, req_addr} + (req_byte ? 33'd0 : 33'd3);
    assign req_err  = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                      (end_addr >= 33'(MEM_BYTES));

    always_comb begin
        if (!byte_q) begin
            load_val = mem_data;
        end else if (signed_q) begin
            load_val = {{24{mem_data[7]}}, mem_data[7:0]};
        end else begin
            load_val = {24'd0, mem_data[7:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    byte_d   = req_byte;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    rdata_d  = 32'd0;
                    state_d  = req_err ? RESP : SETUP;
                end
            end
            SETUP: begin
                wait_d  = 4'd0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    rdata_d = we_q ? 32'd0 : load_val;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            wait_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wait_q   <= wait_d;
        end
    end

    assign in_mem = (state_q == SETUP) || (state_q == ACCESS);

    // Store address/data are also held through RESP so they never move in
    // the cycle right after the write strobe, even with a 1-cycle ACCESS.
    assign store_hold = we_q && !err_q && (in_mem || (state_q == RESP));

    assign mem_en      = (state_q == ACCESS) && we_q && (wait_q == 4'd0);
    assign mem_byte_en = in_mem && byte_q;
    assign mem_raddr   = (in_mem && !we_q) ? addr_q : 32'd0;
    assign mem_waddr   = store_hold ? addr_q : 32'd0;
    assign mem_wdata   = store_hold ? wdata_q : 32'd0;

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MB = 512;
    localparam int W  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_en;
    logic        mem_byte_en;
    logic [31:0] mem_data;

    load_store_unit #(.MEM_BYTES(MB), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_en(mem_en), .mem_byte_en(mem_byte_en), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // ---------------- environment memory ----------------
    logic [7:0] mem [MB];
    logic       mem_init_done = 1'b0;
    int         men_total = 0;

    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < MB; i++) mem[i] <= 8'(i);
            mem_init_done <= 1'b1;
        end else if (mem_en) begin
            men_total <= men_total + 1;
            if (mem_byte_en) begin
                if (mem_waddr < MB) mem[int'(mem_waddr)] <= mem_wdata[7:0];
            end else begin
                for (int k = 0; k < 4; k++)
                    if (mem_waddr + 32'(k) < MB) mem[int'(mem_waddr) + k] <= mem_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        mem_data = 32'd0;
        if (mem_byte_en) begin
            if (mem_raddr < MB) mem_data = {24'd0, mem[int'(mem_raddr)]};
        end else if (mem_raddr <= MB - 4) begin
            mem_data = {mem[int'(mem_raddr) + 3], mem[int'(mem_raddr) + 2],
                        mem[int'(mem_raddr) + 1], mem[int'(mem_raddr)]};
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [MB];
    int n_vec = 0;
    int n_bad = 0;

    function automatic bit ref_err(input bit bt, input logic [31:0] a);
        longint last;
        last = longint'(a) + (bt ? 0 : 3);
        return (!bt && a[1:0] != 2'b00) || (last >= MB);
    endfunction

    task automatic ref_store(input bit bt, input logic [31:0] a, input logic [31:0] wd);
        if (bt) ref_mem[int'(a)] = wd[7:0];
        else for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_load(input bit bt, input bit sg, input logic [31:0] a);
        logic [7:0] b;
        if (!bt)
            return {ref_mem[int'(a) + 3], ref_mem[int'(a) + 2], ref_mem[int'(a) + 1], ref_mem[int'(a)]};
        b = ref_mem[int'(a)];
        return sg ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction with response backpressure of 'hold' cycles.
    task automatic apply(input string tag, input bit we, input bit bt, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         input logic [31:0] exp_rd, input bit exp_er,
                         input int exp_lat, input int exp_men);
        int lat, men0, t;
        logic [31:0] rd;
        logic er;
        bit be_and, be_or, addr_ok, stable;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_byte = bt; req_signed = sg;
        req_addr = a; req_wdata = wd; resp_ready = (hold == 0);
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        men0 = men_total;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_byte = 1'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        be_and = 1'b1; be_or = 1'b0; addr_ok = 1'b1; lat = 1;
        while (!resp_valid && lat < 40) begin
            be_and &= mem_byte_en;
            be_or  |= mem_byte_en;
            if (we) addr_ok &= (mem_waddr == a) && (mem_wdata == wd) && (mem_raddr == 32'd0);
            else    addr_ok &= (mem_raddr == a) && (mem_waddr == 32'd0) && !mem_en;
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            stable &= resp_valid && (resp_rdata == rd) && (resp_err == er) && !req_ready;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_post"}, {30'd0, req_ready, resp_valid}, 32'd2);
        req_valid = 1'b0; resp_ready = 1'b0;
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_men"}, 32'(men_total - men0), 32'(exp_men));
        if (!exp_er) begin
            chk({tag, "_byte_en"}, {30'd0, be_and, be_or}, bt ? 32'd3 : 32'd0);
            chk({tag, "_addr"}, {31'd0, addr_ok}, 32'd1);
        end
        if (hold > 0) chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
        $display("txn %s we=%0b byte=%0b signed=%0b addr=%h wdata=%h hold=%0d -> rdata=%h err=%0b lat=%0d",
                 tag, we, bt, sg, a, wd, hold, rd, er, lat);
    endtask

    typedef struct {
        bit          we;
        bit          bt;
        bit          sg;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic [31:0] exp_rd;
        bit          exp_er;
        int          exp_lat;
        int          exp_men;
    } vec_t;

    initial begin
        vec_t tbl[17];
        int men0, nvalid;
        bit we, bt, sg, er;
        logic [31:0] a, wd, erd;
        int hold;

        for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i);

        //          we bt sg addr           wdata          hold exp_rd         er lat men
        tbl[0]  = '{0, 0, 0, 32'h0000_0008, 32'h0,         0, 32'h0B0A0908, 0, 3, 0};
        tbl[1]  = '{0, 1, 1, 32'h0000_0085, 32'h0,         0, 32'hFFFFFF85, 0, 3, 0};
        tbl[2]  = '{0, 1, 0, 32'h0000_0085, 32'h0,         1, 32'h00000085, 0, 3, 0};
        tbl[3]  = '{1, 0, 0, 32'h0000_0010, 32'hDEADBEEF,  0, 32'h0,        0, 3, 1};
        tbl[4]  = '{0, 0, 0, 32'h0000_0010, 32'h0,         0, 32'hDEADBEEF, 0, 3, 0};
        tbl[5]  = '{0, 0, 0, 32'h0000_000C, 32'h0,         0, 32'h0F0E0D0C, 0, 3, 0};
        tbl[6]  = '{0, 0, 0, 32'h0000_0014, 32'h0,         0, 32'h17161514, 0, 3, 0};
        tbl[7]  = '{0, 0, 0, 32'h0000_0006, 32'h0,         0, 32'h0,        1, 1, 0};
        tbl[8]  = '{0, 1, 0, 32'h0000_0200, 32'h0,         0, 32'h0,        1, 1, 0};
        tbl[9]  = '{1, 0, 0, 32'h0000_0200, 32'h12345678,  0, 32'h0,        1, 1, 0};
        tbl[10] = '{0, 0, 0, 32'hFFFF_FFFC, 32'h0,         0, 32'h0,        1, 1, 0};
        tbl[11] = '{0, 0, 0, 32'h0000_01FC, 32'h0,         0, 32'hFFFEFDFC, 0, 3, 0};
        tbl[12] = '{0, 1, 0, 32'h0000_01FF, 32'h0,         5, 32'h000000FF, 0, 3, 0};
        tbl[13] = '{1, 1, 0, 32'h0000_0030, 32'h123456A5,  2, 32'h0,        0, 3, 1};
        tbl[14] = '{0, 0, 0, 32'h0000_0030, 32'h0,         0, 32'h333231A5, 0, 3, 0};
        tbl[15] = '{0, 1, 1, 32'h0000_01FF, 32'h0,         0, 32'hFFFFFFFF, 0, 3, 0};
        tbl[16] = '{0, 0, 0, 32'h0000_01FD, 32'h0,         3, 32'h0,        1, 1, 0};

        // Reset state
        #12;
        chk("rst_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_en, mem_byte_en}, 32'd0);
        chk("rst_data", resp_rdata | mem_raddr | mem_waddr | mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i].we, tbl[i].bt, tbl[i].sg, tbl[i].addr,
                  tbl[i].wd, tbl[i].hold, tbl[i].exp_rd, tbl[i].exp_er,
                  tbl[i].exp_lat, tbl[i].exp_men);
            if (tbl[i].we && !tbl[i].exp_er) ref_store(tbl[i].bt, tbl[i].addr, tbl[i].wd);
        end

        // Reset pulsed during SETUP of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h55; resp_ready = 1'b1;
        men0 = men_total;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("setup_no_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", {28'd0, mem_en, mem_byte_en, req_ready, resp_valid}, 32'd0);
        chk("midrst_data", mem_waddr | mem_wdata | mem_raddr | resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", {31'd0, req_ready}, 32'd1);
        nvalid = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) nvalid++;
        end
        chk("midrst_no_resp", 32'(nvalid), 32'd0);
        chk("midrst_no_en", 32'(men_total - men0), 32'd0);
        resp_ready = 1'b0;
        $display("txn midrst store byte addr=00000020 abandoned by reset");
        apply("after_rst", 0, 1, 0, 32'h20, 32'h0, 0, 32'h00000020, 0, 3, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom); bt = 1'($urandom); sg = 1'($urandom);
            wd = $urandom; hold = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: a = $urandom;
                1: a = 32'(MB - $urandom_range(0, 4));
                default: begin
                    a = 32'($urandom_range(0, MB - 1));
                    if (!bt && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
                end
            endcase
            er = ref_err(bt, a);
            erd = 32'd0;
            if (!er) begin
                if (we) ref_store(bt, a, wd);
                else    erd = ref_load(bt, sg, a);
            end
            apply($sformatf("rnd%0d", n), we, bt, sg, a, wd, hold, erd, er,
                  er ? 1 : W + 2, (we && !er) ? 1 : 0);
        end

        // Final memory contents against the reference image
        begin
            int diffs;
            diffs = 0;
            for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) diffs++;
            chk("final_mem_diffs", 32'(diffs), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
